reg_file_scoreboard: RTL

- Architectural integer register file: 32 x 32-bit, x0 hardwired to zero.
- Two combinational read ports feed decode.
- One synchronous write port is driven by the write-back stage.
- A per-register pending-write counter (scoreboard) lets decode detect RAW hazards and stall.
- Sits between decode/issue (read + reservation side) and write-back (write + release side).

---
 rtl/reg_file_scoreboard_pkg.sv | 18 +
 rtl/reg_file_scoreboard_if.sv | 42 ++++
 rtl/reg_file_scoreboard_scoreboard_counters.sv | 88 ++++++++
 rtl/reg_file_scoreboard.sv | 65 ++++++
 4 files changed

// File: rtl/reg_file_scoreboard_pkg.sv
// Shared definitions for the register file / scoreboard slice.
// Holds the architectural sizing used by the interface, the top and the
// scoreboard counter block:
//   NUM_REGS   - number of architectural registers (x0 reads as zero)
//   XLEN       - register data width
//   REG_ADDR_W - register address width
//   CNT_W      - width of each pending-write counter
//   CNT_MAX    - saturation point of a counter (outstanding writes per reg)
package reg_file_scoreboard_pkg;

  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Bus between decode/issue + write-back and the register file scoreboard.
//   master : the pipeline side (drives addresses, reservations, write-back)
//   slave  : the register file (returns read data, busy, issue_ready,
//            write_back_done, pending_any)
interface reg_file_scoreboard_if;
  import reg_file_scoreboard_pkg::*;

  // decode read side
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic                  rs1_busy;
  logic                  rs2_busy;
  // issue reservation side
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic                  issue_ready;
  // write-back side
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]       write_data;
  logic                  write_back_done;
  // global control / status
  logic                  flush;
  logic                  pending_any;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_dest,
           write_enable, write_reg, write_data, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready,
           write_back_done, pending_any
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_dest,
           write_enable, write_reg, write_data, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready,
           write_back_done, pending_any
  );

endinterface

// File: rtl/reg_file_scoreboard_scoreboard_counters.sv
// Per-register pending-write counters (the scoreboard).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush               - clears every reservation on the next edge
//   rs1_addr/rs2_addr   - decode read addresses, produce rs1_busy/rs2_busy
//   issue_valid/dest    - reservation request, issue_ready accepts it
//   write_enable/reg    - write-back release of one reservation
//   pending_any         - registered OR of all counters after update
module scoreboard_counters
  import reg_file_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  issue_ready,
  input  logic                  write_enable,
  input  logic [REG_ADDR_W-1:0] write_reg,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  pending_any
);

  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic             any_next;
  logic             inc;
  logic             dec;
  logic             dest_dec;

  // A register is busy unless its only outstanding write is the one being
  // written back (and bypassed) this very cycle.
  function automatic logic busy_of(input logic [CNT_W-1:0]      c,
                                   input logic [REG_ADDR_W-1:0] addr,
                                   input logic                  we,
                                   input logic [REG_ADDR_W-1:0] wr);
    logic hit;
    hit = we && (wr == addr);
    if (addr == '0) return 1'b0;
    return (c > CNT_W'(1)) || ((c == CNT_W'(1)) && !hit);
  endfunction

  // A full counter can still accept a reservation when a write-back frees a
  // slot on the same register in the same cycle.
  always_comb begin
    dest_dec    = write_enable && (write_reg == issue_dest) && (cnt[issue_dest] != '0);
    issue_ready = !((cnt[issue_dest] == CNT_MAX) && !dest_dec);
  end

  always_comb begin
    rs1_busy = busy_of(cnt[rs1_addr], rs1_addr, write_enable, write_reg);
    rs2_busy = busy_of(cnt[rs2_addr], rs2_addr, write_enable, write_reg);
  end

  always_comb begin
    any_next = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = issue_valid && issue_ready && (issue_dest == REG_ADDR_W'(r));
      dec = write_enable && (write_reg == REG_ADDR_W'(r)) && (cnt[r] != '0);
      cnt_next[r] = cnt[r];
      if (r == 0)
        cnt_next[r] = '0;
      else if (inc && !dec)
        cnt_next[r] = cnt[r] + CNT_W'(1);
      else if (dec && !inc)
        cnt_next[r] = cnt[r] - CNT_W'(1);
      any_next = any_next || (cnt_next[r] != '0);
    end
  end

  // Counter state: reset and flush both drop every reservation; a flush
  // also swallows any same-cycle issue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      pending_any <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
      pending_any <= any_next;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural integer register file with RAW scoreboard.
// Ports:
//   clk, reset - clock, synchronous active-high reset (clears data too)
//   bus        - slave side of reg_file_scoreboard_if:
//                two combinational read ports with write-back bypass,
//                one synchronous write port, issue reservations, flush,
//                write_back_done pulse and pending_any status.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  reg_file_scoreboard_if.slave bus
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wb_done_q;

  // Write port and write-back acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      wb_done_q <= 1'b0;
    end else begin
      if (bus.write_enable && (bus.write_reg != '0))
        regs[bus.write_reg] <= bus.write_data;
      wb_done_q <= bus.write_enable;
    end
  end

  assign bus.write_back_done = wb_done_q;

  // Read ports: x0 is forced to zero, then same-cycle write-back wins over
  // the array so a consumer sees the value in the cycle it is written.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == '0)
      bus.rs1_data = '0;
    else if (bus.write_enable && (bus.write_reg == bus.rs1_addr))
      bus.rs1_data = bus.write_data;

    bus.rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == '0)
      bus.rs2_data = '0;
    else if (bus.write_enable && (bus.write_reg == bus.rs2_addr))
      bus.rs2_data = bus.write_data;
  end

  scoreboard_counters u_counters (
    .clk          (clk),
    .reset        (reset),
    .flush        (bus.flush),
    .rs1_addr     (bus.rs1_addr),
    .rs2_addr     (bus.rs2_addr),
    .issue_valid  (bus.issue_valid),
    .issue_dest   (bus.issue_dest),
    .issue_ready  (bus.issue_ready),
    .write_enable (bus.write_enable),
    .write_reg    (bus.write_reg),
    .rs1_busy     (bus.rs1_busy),
    .rs2_busy     (bus.rs2_busy),
    .pending_any  (bus.pending_any)
  );

endmodule
